// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags at issue, captures CDB results, retires in order
// and raises a flush when a mispredicted control-flow instruction reaches the head.
module reorder_buffer #(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned ROB_W    = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_W    = 5
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_rdy,
  input  logic              in_decoder_issue_enable,
  input  logic [REG_W-1:0]  in_decoder_rd,
  input  logic              in_decoder_is_store,
  output logic [ROB_W-1:0]  out_decoder_reorder,
  output logic              out_rob_full,
  input  logic [ROB_W-1:0]  in_decoder_rs_reorder,
  input  logic [ROB_W-1:0]  in_decoder_rt_reorder,
  output logic              out_decoder_rs_ready,
  output logic              out_decoder_rt_ready,
  output logic [DATA_W-1:0] out_decoder_rs_value,
  output logic [DATA_W-1:0] out_decoder_rt_value,
  input  logic              in_cdb_enable,
  input  logic [ROB_W-1:0]  in_cdb_reorder,
  input  logic [DATA_W-1:0] in_cdb_value,
  input  logic              in_cdb_mispredict,
  input  logic [DATA_W-1:0] in_cdb_target_pc,
  output logic              out_reg_commit_enable,
  output logic [REG_W-1:0]  out_reg_rd_addr,
  output logic [DATA_W-1:0] out_reg_rd_value,
  output logic [ROB_W-1:0]  out_reg_reorder,
  output logic              out_lsb_store_commit_enable,
  output logic [ROB_W-1:0]  out_lsb_store_reorder,
  output logic              out_flush_enable,
  output logic [DATA_W-1:0] out_flush_pc
);

  localparam logic [ROB_W-1:0] FirstTag = ROB_W'(1);
  localparam logic [ROB_W-1:0] LastTag  = ROB_W'(ROB_SIZE - 1);

  logic [ROB_SIZE-1:0] busy_q, busy_d;
  logic [ROB_SIZE-1:0] ready_q, ready_d;
  logic [ROB_SIZE-1:0] is_store_q, is_store_d;
  logic [ROB_SIZE-1:0] mispredict_q, mispredict_d;
  logic [REG_W-1:0]    rd_q [ROB_SIZE];
  logic [REG_W-1:0]    rd_d [ROB_SIZE];
  logic [DATA_W-1:0]   value_q [ROB_SIZE];
  logic [DATA_W-1:0]   value_d [ROB_SIZE];
  logic [DATA_W-1:0]   target_pc_q [ROB_SIZE];
  logic [DATA_W-1:0]   target_pc_d [ROB_SIZE];

  logic [ROB_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;

  logic              commit_en_q, commit_en_d;
  logic [REG_W-1:0]  commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0] commit_value_q, commit_value_d;
  logic [ROB_W-1:0]  commit_tag_q, commit_tag_d;
  logic              store_en_q, store_en_d;
  logic [ROB_W-1:0]  store_tag_q, store_tag_d;
  logic              flush_en_q, flush_en_d;
  logic [DATA_W-1:0] flush_pc_q, flush_pc_d;

  logic full, retire, flush, alloc, capture;

  // Tag 0 is the null tag, so pointers wrap from the last slot back to 1.
  function automatic logic [ROB_W-1:0] next_ptr(input logic [ROB_W-1:0] p);
    return (p == LastTag) ? FirstTag : p + FirstTag;
  endfunction

  always_comb begin
    full    = (count_q == LastTag);
    retire  = in_rdy && busy_q[head_q] && ready_q[head_q];
    flush   = retire && mispredict_q[head_q];
    alloc   = in_rdy && in_decoder_issue_enable && !full && !flush;
    capture = in_rdy && in_cdb_enable && busy_q[in_cdb_reorder] && !flush;
  end

  always_comb begin
    busy_d       = busy_q;
    ready_d      = ready_q;
    is_store_d   = is_store_q;
    mispredict_d = mispredict_q;
    rd_d         = rd_q;
    value_d      = value_q;
    target_pc_d  = target_pc_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q + ROB_W'(alloc) - ROB_W'(retire);

    commit_en_d    = retire;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    commit_tag_d   = commit_tag_q;
    store_en_d     = retire && is_store_q[head_q];
    store_tag_d    = store_tag_q;
    flush_en_d     = flush;
    flush_pc_d     = flush_pc_q;

    if (capture) begin
      ready_d[in_cdb_reorder]      = 1'b1;
      value_d[in_cdb_reorder]      = in_cdb_value;
      mispredict_d[in_cdb_reorder] = in_cdb_mispredict;
      target_pc_d[in_cdb_reorder]  = in_cdb_target_pc;
    end

    if (alloc) begin
      busy_d[tail_q]       = 1'b1;
      ready_d[tail_q]      = 1'b0;
      mispredict_d[tail_q] = 1'b0;
      is_store_d[tail_q]   = in_decoder_is_store;
      rd_d[tail_q]         = in_decoder_rd;
      tail_d               = next_ptr(tail_q);
    end

    if (retire) begin
      commit_rd_d          = rd_q[head_q];
      commit_value_d       = value_q[head_q];
      commit_tag_d         = head_q;
      busy_d[head_q]       = 1'b0;
      ready_d[head_q]      = 1'b0;
      mispredict_d[head_q] = 1'b0;
      head_d               = next_ptr(head_q);
      if (is_store_q[head_q]) begin
        store_tag_d = head_q;
      end
    end

    // A mispredict at the head wipes every speculative entry, including this cycle's updates.
    if (flush) begin
      flush_pc_d   = target_pc_q[head_q];
      busy_d       = '0;
      ready_d      = '0;
      mispredict_d = '0;
      head_d       = FirstTag;
      tail_d       = FirstTag;
      count_d      = '0;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      busy_q         <= '0;
      ready_q        <= '0;
      is_store_q     <= '0;
      mispredict_q   <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rd_q[i]        <= '0;
        value_q[i]     <= '0;
        target_pc_q[i] <= '0;
      end
      head_q         <= FirstTag;
      tail_q         <= FirstTag;
      count_q        <= '0;
      commit_en_q    <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
      store_en_q     <= 1'b0;
      store_tag_q    <= '0;
      flush_en_q     <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      is_store_q     <= is_store_d;
      mispredict_q   <= mispredict_d;
      rd_q           <= rd_d;
      value_q        <= value_d;
      target_pc_q    <= target_pc_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_en_q    <= commit_en_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      commit_tag_q   <= commit_tag_d;
      store_en_q     <= store_en_d;
      store_tag_q    <= store_tag_d;
      flush_en_q     <= flush_en_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  // Operand lookup: the live CDB broadcast wins over the stored value.
  always_comb begin
    out_decoder_rs_ready = 1'b0;
    out_decoder_rs_value = '0;
    if (in_decoder_rs_reorder != '0) begin
      if (in_cdb_enable && (in_cdb_reorder == in_decoder_rs_reorder)) begin
        out_decoder_rs_ready = 1'b1;
        out_decoder_rs_value = in_cdb_value;
      end else if (ready_q[in_decoder_rs_reorder]) begin
        out_decoder_rs_ready = 1'b1;
        out_decoder_rs_value = value_q[in_decoder_rs_reorder];
      end
    end
  end

  always_comb begin
    out_decoder_rt_ready = 1'b0;
    out_decoder_rt_value = '0;
    if (in_decoder_rt_reorder != '0) begin
      if (in_cdb_enable && (in_cdb_reorder == in_decoder_rt_reorder)) begin
        out_decoder_rt_ready = 1'b1;
        out_decoder_rt_value = in_cdb_value;
      end else if (ready_q[in_decoder_rt_reorder]) begin
        out_decoder_rt_ready = 1'b1;
        out_decoder_rt_value = value_q[in_decoder_rt_reorder];
      end
    end
  end

  assign out_decoder_reorder         = tail_q;
  assign out_rob_full                = full;
  assign out_reg_commit_enable       = commit_en_q;
  assign out_reg_rd_addr             = commit_rd_q;
  assign out_reg_rd_value            = commit_value_q;
  assign out_reg_reorder             = commit_tag_q;
  assign out_lsb_store_commit_enable = store_en_q;
  assign out_lsb_store_reorder       = store_tag_q;
  assign out_flush_enable            = flush_en_q;
  assign out_flush_pc                = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: table-driven in-order commit plus full/wrap, lookup,
// mispredict flush, stall and mid-stream reset sequences.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        issue;
  logic [4:0]  rd;
  logic        st;
  logic [3:0]  dec_tag;
  logic        full;
  logic [3:0]  rs_tag, rt_tag;
  logic        rs_ready, rt_ready;
  logic [31:0] rs_value, rt_value;
  logic        cdb_en;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic        cdb_mis;
  logic [31:0] cdb_pc;
  logic        commit;
  logic [4:0]  c_rd;
  logic [31:0] c_val;
  logic [3:0]  c_tag;
  logic        lsb_en;
  logic [3:0]  lsb_tag;
  logic        flush;
  logic [31:0] flush_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .in_clk                      (clk),
    .in_rst                      (rst),
    .in_rdy                      (rdy),
    .in_decoder_issue_enable     (issue),
    .in_decoder_rd               (rd),
    .in_decoder_is_store         (st),
    .out_decoder_reorder         (dec_tag),
    .out_rob_full                (full),
    .in_decoder_rs_reorder       (rs_tag),
    .in_decoder_rt_reorder       (rt_tag),
    .out_decoder_rs_ready        (rs_ready),
    .out_decoder_rt_ready        (rt_ready),
    .out_decoder_rs_value        (rs_value),
    .out_decoder_rt_value        (rt_value),
    .in_cdb_enable               (cdb_en),
    .in_cdb_reorder              (cdb_tag),
    .in_cdb_value                (cdb_val),
    .in_cdb_mispredict           (cdb_mis),
    .in_cdb_target_pc            (cdb_pc),
    .out_reg_commit_enable       (commit),
    .out_reg_rd_addr             (c_rd),
    .out_reg_rd_value            (c_val),
    .out_reg_reorder             (c_tag),
    .out_lsb_store_commit_enable (lsb_en),
    .out_lsb_store_reorder       (lsb_tag),
    .out_flush_enable            (flush),
    .out_flush_pc                (flush_pc)
  );

  typedef struct {
    logic        issue;
    logic [4:0]  rd;
    logic        st;
    logic        cdb;
    logic [3:0]  ctag;
    logic [31:0] cval;
    logic        commit;
    logic [4:0]  erd;
    logic [31:0] evalue;
    logic [3:0]  etag;
    logic        lsb;
    logic [3:0]  next;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(logic i, logic [4:0] r, logic s, logic c, logic [3:0] ct,
                              logic [31:0] cv, logic cm, logic [4:0] er, logic [31:0] ev,
                              logic [3:0] et, logic l, logic [3:0] n);
    vec_t v;
    v.issue = i; v.rd = r; v.st = s; v.cdb = c; v.ctag = ct; v.cval = cv;
    v.commit = cm; v.erd = er; v.evalue = ev; v.etag = et; v.lsb = l; v.next = n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rdy = 1'b1; issue = 1'b0; rd = '0; st = 1'b0;
    cdb_en = 1'b0; cdb_tag = '0; cdb_val = '0; cdb_mis = 1'b0; cdb_pc = '0;
    rs_tag = '0; rt_tag = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic commit_chk(input string name, input logic [4:0] er, input logic [31:0] ev,
                            input logic [3:0] et);
    chk({name, "_en"}, 32'(commit), 32'd1);
    chk({name, "_rd"}, 32'(c_rd), 32'(er));
    chk({name, "_val"}, c_val, ev);
    chk({name, "_tag"}, 32'(c_tag), 32'(et));
  endtask

  initial begin
    // Expected values: (rd, value, tag) retire strictly in tag order once the head is ready.
    vecs[0]  = mk(1, 5, 0, 0, 0, 0,        0, 0, 0,        0, 0, 2);
    vecs[1]  = mk(1, 6, 0, 0, 0, 0,        0, 0, 0,        0, 0, 3);
    vecs[2]  = mk(1, 7, 0, 0, 0, 0,        0, 0, 0,        0, 0, 4);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 4);
    vecs[4]  = mk(0, 0, 0, 1, 2, 32'hAA,   0, 0, 0,        0, 0, 4);
    vecs[5]  = mk(0, 0, 0, 1, 1, 32'h11,   0, 0, 0,        0, 0, 4);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0,        1, 5, 32'h11,   1, 0, 4);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0,        1, 6, 32'hAA,   2, 0, 4);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 4);
    vecs[9]  = mk(1, 0, 1, 1, 3, 32'h33,   0, 0, 0,        0, 0, 5);
    vecs[10] = mk(0, 0, 0, 1, 4, 32'h44,   1, 7, 32'h33,   3, 0, 5);
    vecs[11] = mk(0, 0, 0, 0, 0, 0,        1, 0, 32'h44,   4, 1, 5);
    vecs[12] = mk(0, 0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 5);

    do_reset();
    chk("rst_commit", 32'(commit), 32'd0);
    chk("rst_lsb", 32'(lsb_en), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_tag", 32'(dec_tag), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rdval", c_val, 32'd0);

    for (int i = 0; i < 13; i++) begin
      idle();
      issue = vecs[i].issue; rd = vecs[i].rd; st = vecs[i].st;
      cdb_en = vecs[i].cdb; cdb_tag = vecs[i].ctag; cdb_val = vecs[i].cval;
      step();
      chk($sformatf("v%0d_commit", i), 32'(commit), 32'(vecs[i].commit));
      chk($sformatf("v%0d_lsb", i), 32'(lsb_en), 32'(vecs[i].lsb));
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'd0);
      chk($sformatf("v%0d_next", i), 32'(dec_tag), 32'(vecs[i].next));
      if (vecs[i].commit) begin
        chk($sformatf("v%0d_rd", i), 32'(c_rd), 32'(vecs[i].erd));
        chk($sformatf("v%0d_val", i), c_val, vecs[i].evalue);
        chk($sformatf("v%0d_tag", i), 32'(c_tag), 32'(vecs[i].etag));
      end
      if (vecs[i].lsb) chk($sformatf("v%0d_lsbtag", i), 32'(lsb_tag), 32'(vecs[i].etag));
    end

    // Fill all 15 slots, try a 16th, then retire one and wrap past tag 15 to tag 1.
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      idle(); issue = 1'b1; rd = 5'(i);
      step();
    end
    chk("full_set", 32'(full), 32'd1);
    chk("full_tag", 32'(dec_tag), 32'd1);
    idle(); issue = 1'b1; rd = 5'd31;
    step();
    chk("full_ignore_tag", 32'(dec_tag), 32'd1);
    chk("full_ignore_full", 32'(full), 32'd1);
    idle(); cdb_en = 1'b1; cdb_tag = 4'd1; cdb_val = 32'h77;
    step();
    chk("full_nocommit", 32'(commit), 32'd0);
    idle();
    step();
    commit_chk("full_retire", 5'd1, 32'h77, 4'd1);
    chk("full_drop", 32'(full), 32'd0);
    chk("wrap_tag", 32'(dec_tag), 32'd1);
    idle(); issue = 1'b1; rd = 5'd20;
    cdb_en = 1'b1; cdb_tag = 4'd4; cdb_val = 32'h55; rs_tag = 4'd4; rt_tag = 4'd5;
    #1;
    chk("fwd_rs_ready", 32'(rs_ready), 32'd1);
    chk("fwd_rs_value", rs_value, 32'h55);
    chk("fwd_rt_ready", 32'(rt_ready), 32'd0);
    step();
    chk("wrap_next", 32'(dec_tag), 32'd2);
    chk("wrap_full", 32'(full), 32'd1);
    idle(); rs_tag = 4'd4; rt_tag = 4'd0;
    #1;
    chk("stored_rs_ready", 32'(rs_ready), 32'd1);
    chk("stored_rs_value", rs_value, 32'h55);
    chk("null_rt_ready", 32'(rt_ready), 32'd0);
    chk("null_rt_value", rt_value, 32'd0);

    // Mispredicted jump at the head: link commit and flush in one cycle, then everything gone.
    do_reset();
    idle(); issue = 1'b1; rd = 5'd1;
    step();
    idle(); issue = 1'b1; rd = 5'd2;
    step();
    idle(); cdb_en = 1'b1; cdb_tag = 4'd1; cdb_val = 32'h24; cdb_mis = 1'b1;
    cdb_pc = 32'h1000;
    step();
    chk("mis_early", 32'(commit | flush), 32'd0);
    idle(); issue = 1'b1; rd = 5'd9; cdb_en = 1'b1; cdb_tag = 4'd2; cdb_val = 32'h99;
    step();
    commit_chk("mis_link", 5'd1, 32'h24, 4'd1);
    chk("mis_flush", 32'(flush), 32'd1);
    chk("mis_pc", flush_pc, 32'h1000);
    chk("mis_tag", 32'(dec_tag), 32'd1);
    chk("mis_full", 32'(full), 32'd0);
    idle();
    step();
    chk("mis_pulse_commit", 32'(commit), 32'd0);
    chk("mis_pulse_flush", 32'(flush), 32'd0);
    idle(); cdb_en = 1'b1; cdb_tag = 4'd2; cdb_val = 32'h99;
    step();
    idle(); rs_tag = 4'd2;
    step();
    chk("stale_cdb_commit", 32'(commit), 32'd0);
    chk("stale_cdb_ready", 32'(rs_ready), 32'd0);

    // Stall with a ready head, then release; then reset asynchronously mid-pulse.
    do_reset();
    idle(); issue = 1'b1; rd = 5'd9;
    step();
    idle(); cdb_en = 1'b1; cdb_tag = 4'd1; cdb_val = 32'h9;
    step();
    idle(); rdy = 1'b0; issue = 1'b1; rd = 5'd3;
    step();
    chk("stall_commit0", 32'(commit), 32'd0);
    chk("stall_tag", 32'(dec_tag), 32'd2);
    step();
    chk("stall_commit1", 32'(commit), 32'd0);
    idle();
    step();
    commit_chk("stall_release", 5'd9, 32'h9, 4'd1);
    rst = 1'b1;
    #1;
    chk("arst_commit", 32'(commit), 32'd0);
    chk("arst_rd", 32'(c_rd), 32'd0);
    chk("arst_val", c_val, 32'd0);
    chk("arst_tag", 32'(c_tag), 32'd0);
    chk("arst_next", 32'(dec_tag), 32'd1);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
